pr_request_queue: RTL and testbench
===================================

Name: pr_request_queue

Overview:
- Parametrised, multi-channel partial-reconfiguration request queue; successor to the single-channel AXI PR queue.
- Core-side logic pushes reconfiguration requests, each tagged with a target RCA channel (slot).
- A host pops requests and signals per-channel completion over an AXI-lite slave.
- Tracks one outstanding request per channel; raises pr_request_pending while any request is queued.

Parameters:
DEPTH, 8, queue entries; power of two, >= 2
NUM_CHANNELS, 4, number of reconfigurable channels; 2..128
REQ_W, 16, request payload width; 1..24

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset (acts on posedge clk when 0)
push_valid  input  1  core request valid
push_ready  output  1  request accepted this cycle when push_valid and push_ready are both 1
push_channel  input  $clog2(NUM_CHANNELS)  target channel
push_payload  input  REQ_W  request payload (bitstream/config id)
chan_busy  output  NUM_CHANNELS  per-channel request outstanding (queued or popped, not completed)
chan_done  output  NUM_CHANNELS  one-cycle completion pulse per channel
s_axi_awaddr  input  4  write address
s_axi_awvalid  input  1  write address valid
s_axi_awready  output  1  write address ready
s_axi_wdata  input  32  write data
s_axi_wvalid  input  1  write data valid
s_axi_wready  output  1  write data ready
s_axi_bvalid  output  1  write response valid (response always OKAY)
s_axi_bready  input  1  write response ready
s_axi_araddr  input  4  read address
s_axi_arvalid  input  1  read address valid
s_axi_arready  output  1  read address ready
s_axi_rdata  output  32  read data
s_axi_rvalid  output  1  read data valid
s_axi_rready  input  1  read data ready
pr_request_pending  output  1  queue non-empty (count != 0), combinational from registered count

Behaviour:
- Reset (rst==0 at edge): read/write pointers, count and chan_busy cleared; chan_done=0; bvalid=rvalid=0; rdata=0. Reset mid-transaction drops all AXI state and queued requests with no responses issued.
- Queue storage is a FIFO of {channel, payload}. Width of count is $clog2(DEPTH)+1.
- push_ready = !full && !chan_busy[push_channel] && !(flush write accepted this cycle). chan_busy is registered, so a same-cycle completion does not unblock a push.
- Accepted push: write entry, increment count, set chan_busy[push_channel] next cycle.
- AXI write: s_axi_awready = s_axi_wready = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid; both handshake together.
  - The write takes effect in the handshake cycle.
  - bvalid rises on the next cycle and holds until bready.
  - Address decode uses awaddr[3:2].
- AXI read: s_axi_arready = !s_axi_rvalid.
  - On handshake, rdata is latched and rvalid is set the next cycle, held until rready.
  - Any pop happens in the handshake cycle.
- Register map, read:
  - 0x0 HEAD: if non-empty, {1'b1, 7-bit channel, 24-bit zero-extended payload} and the head is popped. If empty, returns 0 with no pop.
  - 0x4 STATUS: {zeros, count[15:0] in bits 15:0}; bit 16 full, bit 17 empty.
  - 0x8 BUSY: chan_busy zero-extended.
  - 0xC: returns 0.
- Register map, write:
  - 0x0 DONE: wdata[6:0]=channel. If in range and busy, clear chan_busy and pulse chan_done for exactly one cycle, the cycle after the handshake. Otherwise ignored.
  - 0x4 CTRL: bit 0=1 flushes. Pointers and count go to 0, all chan_busy bits clear, no chan_done pulses.
  - Other addresses are ignored, but bvalid is still returned.
- Simultaneous push and pop: count unchanged, both succeed. A push while full is never accepted, even with a pop in the same cycle.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0).

Test Plan:
- Reset: drive rst=0 for 2 cycles -> push_ready=1, pr_request_pending=0, chan_busy=0, bvalid=rvalid=0. Read 0x4 -> 0x00020000.
- Push ch2/payload 0x1234 -> pr_request_pending=1, chan_busy=0b0100. Second push to ch2 -> push_ready=0. Read 0x0 -> 0x82001234. Write 0x0 data 2 -> chan_done[2] pulses 1 cycle, chan_busy=0.
- Fill: NUM_CHANNELS=8, DEPTH=8, push ch0..7 -> count=8, full, push_ready=0. Pop all 8 -> channels 0..7 in order, then HEAD returns 0x00000000. Then 3 more push/pop rounds verify pointer wrap.
- Simultaneous push of ch1 with HEAD pop at count=3 -> count stays 3; next pop returns the oldest entry.
- Flush with 4 queued -> count=0, chan_busy=0, no chan_done. A push presented in the same cycle sees push_ready=0.
- Backpressure: hold rready=0 for 5 cycles after a read -> rvalid, rdata stable and arready=0. Assert reset mid-read -> rvalid=0 next cycle, queue empty.

Source files
------------

// File: rtl/pr_request_queue.sv
// Multi-channel partial-reconfiguration request queue: core pushes {channel, payload},
// host pops heads, reads status and signals per-channel completion over AXI-lite.
module pr_request_queue #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned REQ_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_valid,
    output logic                            push_ready,
    input  logic [$clog2(NUM_CHANNELS)-1:0] push_channel,
    input  logic [REQ_W-1:0]                push_payload,
    output logic [NUM_CHANNELS-1:0]         chan_busy,
    output logic [NUM_CHANNELS-1:0]         chan_done,
    input  logic [3:0]                      s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [31:0]                     s_axi_wdata,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [3:0]                      s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [31:0]                     s_axi_rdata,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            pr_request_pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CH_W  = $clog2(NUM_CHANNELS);

    logic [CH_W-1:0]         r_mem_ch [DEPTH];
    logic [REQ_W-1:0]        r_mem_pl [DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [CNT_W-1:0]        r_count;
    logic [NUM_CHANNELS-1:0] r_busy;
    logic [NUM_CHANNELS-1:0] r_done;
    logic                    r_bvalid;
    logic                    r_rvalid;
    logic [31:0]             r_rdata;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_hs;
    logic                    w_rd_hs;
    logic                    w_flush;
    logic                    w_done_ok;
    logic [CH_W-1:0]         w_done_idx;
    logic                    w_push_ch_ok;
    logic                    w_push;
    logic                    w_pop;
    logic [31:0]             w_rdata;
    logic [NUM_CHANNELS-1:0] w_busy_nxt;
    logic [NUM_CHANNELS-1:0] w_done_nxt;
    logic                    w_unused;

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_wr_hs      = s_axi_awvalid && s_axi_wvalid && !r_bvalid;
    assign w_rd_hs      = s_axi_arvalid && !r_rvalid;
    assign w_flush      = w_wr_hs && (s_axi_awaddr[3:2] == 2'd1) && s_axi_wdata[0];
    assign w_done_idx   = CH_W'(s_axi_wdata[6:0]);
    assign w_done_ok    = w_wr_hs && (s_axi_awaddr[3:2] == 2'd0)
                          && (32'(s_axi_wdata[6:0]) < NUM_CHANNELS) && r_busy[w_done_idx];
    assign w_push_ch_ok = (32'(push_channel) < NUM_CHANNELS);
    assign push_ready   = !w_full && w_push_ch_ok && !r_busy[push_channel] && !w_flush;
    assign w_push       = push_valid && push_ready;
    assign w_pop        = w_rd_hs && (s_axi_araddr[3:2] == 2'd0) && !w_empty;
    assign w_unused     = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:7]};

    assign s_axi_awready      = w_wr_hs;
    assign s_axi_wready       = w_wr_hs;
    assign s_axi_arready      = !r_rvalid;
    assign s_axi_bvalid       = r_bvalid;
    assign s_axi_rvalid       = r_rvalid;
    assign s_axi_rdata        = r_rdata;
    assign chan_busy          = r_busy;
    assign chan_done          = r_done;
    assign pr_request_pending = !w_empty;

    // Read mux; HEAD read returns the entry being popped in the same cycle
    always_comb begin
        w_rdata = '0;
        case (s_axi_araddr[3:2])
            2'd0: if (!w_empty) w_rdata = {1'b1, 7'(r_mem_ch[r_rptr]), 24'(r_mem_pl[r_rptr])};
            2'd1: w_rdata = {14'd0, w_empty, w_full, 16'(r_count)};
            2'd2: w_rdata = 32'(r_busy);
            default: w_rdata = '0;
        endcase
    end

    // Busy set on push, cleared on completion or flush; push and done never hit the same bit
    always_comb begin
        w_busy_nxt = r_busy;
        w_done_nxt = '0;
        if (w_push)
            w_busy_nxt[push_channel] = 1'b1;
        if (w_done_ok) begin
            w_busy_nxt[w_done_idx] = 1'b0;
            w_done_nxt[w_done_idx] = 1'b1;
        end
        if (w_flush)
            w_busy_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ch[r_wptr] <= push_channel;
            r_mem_pl[r_wptr] <= push_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_done   <= '0;
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
            if (w_wr_hs)
                r_bvalid <= 1'b1;
            else if (s_axi_bready)
                r_bvalid <= 1'b0;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
            end else if (s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pr_request_queue.sv
// Directed bench for pr_request_queue (DEPTH=8, NUM_CHANNELS=8) with hand-computed expectations.
module tb_pr_request_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [2:0]  push_channel;
    logic [15:0] push_payload;
    logic [7:0]  chan_busy;
    logic [7:0]  chan_done;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        pending;

    int n_tests = 0;
    int n_fail  = 0;

    pr_request_queue #(.DEPTH(8), .NUM_CHANNELS(8), .REQ_W(16)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_channel(push_channel), .push_payload(push_payload),
        .chan_busy(chan_busy), .chan_done(chan_done),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .pr_request_pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] ch, input logic [15:0] pl);
        push_valid = 1'b1; push_channel = ch; push_payload = pl;
        #1;
        check("push_ready", 32'(push_ready), 32'd1);
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!awready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("aw_hs", 32'(awready && wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid", 32'(bvalid), 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ar_hs", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid", 32'(rvalid), 32'd1);
        d = rdata;
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1'b0; push_valid = 1'b0; push_channel = '0; push_payload = '0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_push_ready", 32'(push_ready), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_busy", 32'(chan_busy), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        axi_read(4'h4, rd);
        check("rst_status", rd, 32'h0002_0000);

        // Single request lifecycle
        push(3'd2, 16'h1234);
        check("pend_after_push", 32'(pending), 32'd1);
        check("busy_ch2", 32'(chan_busy), 32'h04);
        push_valid = 1'b1; push_channel = 3'd2; #1;
        check("busy_blocks_push", 32'(push_ready), 32'd0);
        push_valid = 1'b0;
        axi_read(4'h0, rd);
        check("head_ch2", rd, 32'h8200_1234);
        check("busy_after_pop", 32'(chan_busy), 32'h04);
        axi_write(4'h0, 32'd2);
        check("done_pulse", 32'(chan_done), 32'h04);
        check("busy_cleared", 32'(chan_busy), 32'h00);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(chan_done), 32'h00);

        // Fill to DEPTH (write pointer wraps from slot 1), then drain in order
        for (int i = 0; i < 8; i++) push(3'(i), 16'(16'h0100 + i));
        axi_read(4'h4, rd);
        check("full_status", rd, 32'h0001_0008);
        check("full_push_ready", 32'(push_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            axi_read(4'h0, rd);
            check("drain_head", rd, 32'h8000_0000 | (32'(i) << 24) | 32'(16'h0100 + i));
        end
        axi_read(4'h0, rd);
        check("empty_head", rd, 32'h0000_0000);
        axi_read(4'h8, rd);
        check("busy_reg", rd, 32'h0000_00FF);
        for (int i = 0; i < 8; i++) axi_write(4'h0, 32'(i));
        check("all_done", 32'(chan_busy), 32'h00);

        // Push/pop rounds across wrapped pointers
        for (int r = 0; r < 3; r++) begin
            push(3'(r + 5), 16'(16'h00A0 + r));
            axi_read(4'h0, rd);
            check("round_head", rd, 32'h8000_0000 | (32'(r + 5) << 24) | 32'(16'h00A0 + r));
            axi_write(4'h0, 32'(r + 5));
        end
        check("round_busy", 32'(chan_busy), 32'h00);

        // Simultaneous push and pop at count=3
        push(3'd3, 16'h0030);
        push(3'd4, 16'h0040);
        push(3'd5, 16'h0050);
        push_valid = 1'b1; push_channel = 3'd1; push_payload = 16'h0011;
        araddr = 4'h0; arvalid = 1'b1;
        #1;
        check("sim_push_ready", 32'(push_ready), 32'd1);
        check("sim_arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        push_valid = 1'b0; arvalid = 1'b0;
        check("sim_head", rdata, 32'h8300_0030);
        axi_read(4'h4, rd);
        check("sim_count", rd, 32'h0000_0003);
        axi_read(4'h0, rd);
        check("sim_next_head", rd, 32'h8400_0040);
        push(3'd6, 16'h0060);
        push(3'd7, 16'h0070);
        check("pre_flush_busy", 32'(chan_busy), 32'hFA);

        // Flush with 4 queued and a push presented in the handshake cycle
        awaddr = 4'h4; wdata = 32'd1; awvalid = 1'b1; wvalid = 1'b1;
        push_valid = 1'b1; push_channel = 3'd0; push_payload = 16'hBEEF;
        #1;
        check("flush_hs", 32'(awready), 32'd1);
        check("flush_blocks_push", 32'(push_ready), 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; push_valid = 1'b0;
        check("flush_busy", 32'(chan_busy), 32'h00);
        check("flush_no_done", 32'(chan_done), 32'h00);
        check("flush_pending", 32'(pending), 32'd0);
        axi_read(4'h4, rd);
        check("flush_status", rd, 32'h0002_0000);

        // Read backpressure then reset mid-transaction
        push(3'd2, 16'h2222);
        rready = 1'b0;
        araddr = 4'h0; arvalid = 1'b1;
        #1;
        check("bp_arready0", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", 32'(rvalid), 32'd1);
            check("bp_rdata", rdata, 32'h8200_2222);
            check("bp_arready", 32'(arready), 32'd0);
            @(posedge clk); #1;
        end
        push(3'd3, 16'h3333);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_pending", 32'(pending), 32'd0);
        check("rst_mid_busy", 32'(chan_busy), 32'h00);
        check("rst_mid_rdata", rdata, 32'h0000_0000);
        rst = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        axi_read(4'h0, rd);
        check("rst_mid_head", rd, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
